// File: rtl/ysyx_220053_mem_arb_if.sv
// Handshake bundle between the IFU/LSU requesters, the memory
// arbiter and the 64-bit data-memory port.
interface ysyx_220053_mem_arb_if #(
  parameter int AW = 64,
  parameter int DW = 64
);
  logic          ifu_valid;
  logic [AW-1:0] ifu_addr;
  logic          ifu_ready;
  logic          ifu_rvalid;
  logic [DW-1:0] ifu_rdata;

  logic          lsu_valid;
  logic          lsu_we;
  logic [2:0]    lsu_memop;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_ready;
  logic          lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          lsu_err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  ifu_valid, ifu_addr,
    output ifu_ready, ifu_rvalid, ifu_rdata,
    input  lsu_valid, lsu_we, lsu_memop,
    input  lsu_addr, lsu_wdata,
    output lsu_ready, lsu_rvalid,
    output lsu_rdata, lsu_err,
    output mem_req, mem_we, mem_addr,
    output mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output ifu_valid, ifu_addr,
    input  ifu_ready, ifu_rvalid, ifu_rdata,
    output lsu_valid, lsu_we, lsu_memop,
    output lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_rvalid,
    input  lsu_rdata, lsu_err,
    input  mem_req, mem_we, mem_addr,
    input  mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/ysyx_220053_mem_arb.sv
// Round-robin IFU/LSU arbiter for one 64-bit memory port with
// byte-lane alignment, write masking and load extension.
module ysyx_220053_mem_arb #(
  parameter int AW = 64,
  parameter int DW = 64
) (
  input logic clk,
  input logic rst_n,
  ysyx_220053_mem_arb_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RESP, S_ERR
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          own_q, own_d;
  logic          we_q, we_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    wmask_q, wmask_d;

  logic          gnt_ifu, gnt_lsu;
  logic [2:0]    st;
  logic [7:0]    size_m;
  logic          misal;
  logic [DW-1:0] lane, wsh, rsh, rext;

  // last_q = 1 means the LSU won the previous grant
  assign gnt_ifu = bus.ifu_valid
                 & (~bus.lsu_valid | last_q);
  assign gnt_lsu = bus.lsu_valid
                 & (~bus.ifu_valid | ~last_q);

  assign st = bus.lsu_addr[2:0];

  always_comb begin
    size_m = 8'hFF;
    misal  = (st != 3'd0);
    unique case (bus.lsu_memop[1:0])
      2'b00: begin
        size_m = 8'h0F;
        misal  = (st[1:0] != 2'd0);
      end
      2'b01: begin
        size_m = 8'h01;
        misal  = 1'b0;
      end
      2'b10: begin
        size_m = 8'h03;
        misal  = st[0];
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    assign lane[8*i +: 8] = {8{size_m[i]}};
  end

  assign wsh = (bus.lsu_wdata & lane)
             << {st, 3'b000};
  assign rsh = rdata_q >> {addr_q[2:0], 3'b000};

  always_comb begin
    rext = rsh;
    unique case (op_q)
      3'b000: rext = {{32{rsh[31]}}, rsh[31:0]};
      3'b001: rext = {{56{rsh[7]}}, rsh[7:0]};
      3'b010: rext = {{48{rsh[15]}}, rsh[15:0]};
      3'b100: rext = {32'b0, rsh[31:0]};
      3'b101: rext = {56'b0, rsh[7:0]};
      3'b110: rext = {48'b0, rsh[15:0]};
      3'b111: rext = '0;
      default: rext = rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      we_q    <= 1'b0;
      op_q    <= 3'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wmask_q <= 8'h0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wmask_q <= wmask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wmask_d = wmask_q;

    bus.ifu_ready  = 1'b0;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = '0;
    bus.lsu_ready  = 1'b0;
    bus.lsu_rvalid = 1'b0;
    bus.lsu_rdata  = '0;
    bus.lsu_err    = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wmask  = 8'h0;

    unique case (state_q)
      S_IDLE: begin
        unique case (1'b1)
          gnt_ifu: begin
            bus.ifu_ready = 1'b1;
            own_d   = 1'b0;
            last_d  = 1'b0;
            we_d    = 1'b0;
            op_d    = 3'b100;
            addr_d  = bus.ifu_addr;
            wdata_d = '0;
            wmask_d = 8'h0;
            state_d = S_REQ;
          end
          gnt_lsu: begin
            bus.lsu_ready = 1'b1;
            own_d   = 1'b1;
            last_d  = 1'b1;
            we_d    = bus.lsu_we;
            op_d    = bus.lsu_memop;
            addr_d  = bus.lsu_addr;
            wdata_d = bus.lsu_we ? wsh : '0;
            wmask_d = bus.lsu_we
                    ? (size_m << st) : 8'h0;
            state_d = misal ? S_ERR : S_REQ;
          end
          default: ;
        endcase
      end
      S_REQ: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = {addr_q[AW-1:3], 3'b000};
        bus.mem_wdata = wdata_q;
        bus.mem_wmask = wmask_q;
        if (bus.mem_ready) begin
          state_d = S_WAIT;
          if (bus.mem_rvalid) begin
            rdata_d = bus.mem_rdata;
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (own_q) begin
          bus.lsu_rvalid = 1'b1;
          bus.lsu_rdata  = we_q ? '0 : rext;
        end else begin
          bus.ifu_rvalid = 1'b1;
          bus.ifu_rdata  = (addr_q[1:0] != 2'd0)
                         ? '0 : rext;
        end
        state_d = S_IDLE;
      end
      S_ERR: begin
        bus.lsu_rvalid = 1'b1;
        bus.lsu_err    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ysyx_220053_mem_arb.sv
// Bench for the IFU/LSU memory arbiter: vector table, corner
// sequences and random traffic against a byte-level model.
module tb_ysyx_220053_mem_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_220053_mem_arb_if #(.AW(64), .DW(64)) bus();

  ysyx_220053_mem_arb #(.AW(64), .DW(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  bit          manual = 1'b0;
  logic        man_ready = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [63:0] man_rdata = '0;
  logic        r_ready = 1'b0;
  logic        r_rvalid = 1'b0;
  logic [63:0] r_rdata = '0;

  assign bus.mem_ready  = manual ? man_ready : r_ready;
  assign bus.mem_rvalid = manual ? man_rvalid : r_rvalid;
  assign bus.mem_rdata  = manual ? man_rdata : r_rdata;

  int          rdy_lat = 0;
  int          rv_lat = 0;
  int          req_cnt = 0;
  int          cnt = 0;
  int          wcnt = 0;
  logic [63:0] mem_data = '0;
  logic [63:0] cap_addr = '0;
  logic [63:0] cap_wdata = '0;
  logic [7:0]  cap_wmask = '0;
  logic        cap_we = 1'b0;

  // Memory responder: accepts after rdy_lat stalled cycles, then
  // returns data rv_lat cycles later (0 = same cycle as accept).
  always @(negedge clk) begin
    r_ready  = 1'b0;
    r_rvalid = 1'b0;
    if (!rst_n || manual) begin
      cnt  = 0;
      wcnt = 0;
    end else if (bus.mem_req) begin
      if (cnt == rdy_lat) begin
        r_ready   = 1'b1;
        cap_addr  = bus.mem_addr;
        cap_wdata = bus.mem_wdata;
        cap_wmask = bus.mem_wmask;
        cap_we    = bus.mem_we;
        req_cnt++;
        cnt = 0;
        if (rv_lat == 0) begin
          r_rvalid = 1'b1;
          r_rdata  = mem_data;
        end else begin
          wcnt = rv_lat;
        end
      end else begin
        cnt++;
      end
    end else if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) begin
        r_rvalid = 1'b1;
        r_rdata  = mem_data;
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] op);
    case (op[1:0])
      2'd0: return 4;
      2'd1: return 1;
      2'd2: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] op,
                                 input logic [63:0] a);
    return (int'(a[2:0]) % nbytes(op)) != 0;
  endfunction

  function automatic logic [63:0] ref_load(
      input logic [2:0] op, input logic [63:0] a,
      input logic [63:0] d);
    int n = nbytes(op);
    int s = int'(a[2:0]);
    logic [63:0] v = '0;
    if (op == 3'b111) return '0;
    for (int i = 0; i < n; i++)
      v[8*i +: 8] = d[8*(s+i) +: 8];
    if (!op[2] && v[8*n-1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_mask(
      input logic [2:0] op, input logic [63:0] a);
    logic [7:0] m = '0;
    for (int i = 0; i < nbytes(op); i++)
      m[int'(a[2:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wd(
      input logic [2:0] op, input logic [63:0] a,
      input logic [63:0] d);
    logic [63:0] w = '0;
    int s = int'(a[2:0]);
    for (int i = 0; i < nbytes(op); i++)
      w[8*(s+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] ref_ifu(
      input logic [63:0] a, input logic [63:0] d);
    if (a[1:0] != 2'd0) return '0;
    return ref_load(3'b100, a, d);
  endfunction

  task automatic xact(input bit is_lsu, input bit we,
                      input logic [2:0] op,
                      input logic [63:0] addr,
                      input logic [63:0] wd,
                      input logic [63:0] md,
                      input int r, input int k,
                      output logic [63:0] got,
                      output logic err,
                      output int lat, output int nreq);
    int n;
    int base;
    @(negedge clk);
    rdy_lat  = r;
    rv_lat   = k;
    mem_data = md;
    base     = req_cnt;
    bus.lsu_we    = we;
    bus.lsu_memop = op;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wd;
    bus.ifu_addr  = addr;
    bus.lsu_valid = is_lsu;
    bus.ifu_valid = !is_lsu;
    #1;
    n = 0;
    while (!(is_lsu ? bus.lsu_ready : bus.ifu_ready)
           && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) chk("ready_timeout", 64'(n), 64'd0);
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    bus.ifu_valid = 1'b0;
    #1;
    lat = 1;
    while (!(is_lsu ? bus.lsu_rvalid : bus.ifu_rvalid)
           && lat < 40) begin
      @(negedge clk); #1; lat++;
    end
    got = is_lsu ? bus.lsu_rdata : bus.ifu_rdata;
    err = bus.lsu_err;
    chk("other_rvalid", 64'(is_lsu ? bus.ifu_rvalid
                                    : bus.lsu_rvalid), 64'd0);
    @(negedge clk); #1;
    chk("rvalid_one_cycle",
        64'(is_lsu ? bus.lsu_rvalid : bus.ifu_rvalid), 64'd0);
    nreq = req_cnt - base;
  endtask

  typedef struct {
    bit          lsu;
    bit          we;
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] md;
    logic [63:0] exp_rd;
    bit          exp_err;
    logic [63:0] exp_maddr;
    logic [7:0]  exp_m;
    logic [63:0] exp_wd;
  } vec_t;

  vec_t tv[17];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    logic        err;
    int          lat, nreq, pulses;
    int          order[$];
    logic [63:0] ones;
    ones = 64'hFFFF_FFFF_FFFF_FFFF;

    tv[0]  = '{1, 0, 3'b000, 64'h8000_0004, 0,
               64'h8765_4321_0000_0000,
               64'hFFFF_FFFF_8765_4321, 0,
               64'h8000_0000, 0, 0};
    tv[1]  = '{1, 1, 3'b001, 64'h8000_0005, 64'hAB, ones,
               0, 0, 64'h8000_0000, 8'h20,
               64'h0000_AB00_0000_0000};
    tv[2]  = '{1, 0, 3'b101, 64'h8000_0007, 0,
               64'h9A00_0000_0000_0000, 64'h9A, 0,
               64'h8000_0000, 0, 0};
    tv[3]  = '{1, 0, 3'b001, 64'h8000_0007, 0,
               64'h9A00_0000_0000_0000,
               64'hFFFF_FFFF_FFFF_FF9A, 0,
               64'h8000_0000, 0, 0};
    tv[4]  = '{1, 0, 3'b010, 64'h8000_0002, 0,
               64'h0000_0000_8001_0000,
               64'hFFFF_FFFF_FFFF_8001, 0,
               64'h8000_0000, 0, 0};
    tv[5]  = '{1, 0, 3'b110, 64'h8000_0002, 0,
               64'h0000_0000_8001_0000, 64'h8001, 0,
               64'h8000_0000, 0, 0};
    tv[6]  = '{1, 0, 3'b011, 64'h8000_0008, 0,
               64'h0123_4567_89AB_CDEF,
               64'h0123_4567_89AB_CDEF, 0,
               64'h8000_0008, 0, 0};
    tv[7]  = '{1, 0, 3'b111, 64'h8000_0010, 0,
               64'hDEAD_BEEF_DEAD_BEEF, 0, 0,
               64'h8000_0010, 0, 0};
    tv[8]  = '{1, 1, 3'b010, 64'h8000_0006,
               64'hFFFF_FFFF_FFFF_BEEF, ones, 0, 0,
               64'h8000_0000, 8'hC0,
               64'hBEEF_0000_0000_0000};
    tv[9]  = '{1, 1, 3'b100, 64'h8000_0004,
               64'hCAFE_BABE_1234_5678, ones, 0, 0,
               64'h8000_0000, 8'hF0,
               64'h1234_5678_0000_0000};
    tv[10] = '{1, 0, 3'b010, 64'h8000_0003, 0, ones,
               0, 1, 0, 0, 0};
    tv[11] = '{1, 1, 3'b000, 64'h8000_0006, 1, ones,
               0, 1, 0, 0, 0};
    tv[12] = '{1, 0, 3'b011, 64'h8000_0004, 0, ones,
               0, 1, 0, 0, 0};
    tv[13] = '{0, 0, 3'b000, 64'h8000_0004, 0,
               64'h1234_5678_9ABC_DEF0, 64'h1234_5678, 0,
               64'h8000_0000, 0, 0};
    tv[14] = '{0, 0, 3'b000, 64'h8000_0000, 0,
               64'h1234_5678_9ABC_DEF0, 64'h9ABC_DEF0, 0,
               64'h8000_0000, 0, 0};
    tv[15] = '{0, 0, 3'b000, 64'h8000_0002, 0,
               64'h1234_5678_9ABC_DEF0, 0, 0,
               64'h8000_0000, 0, 0};
    tv[16] = '{1, 1, 3'b011, 64'h8000_0018,
               64'h1122_3344_5566_7788, ones, 0, 0,
               64'h8000_0018, 8'hFF,
               64'h1122_3344_5566_7788};

    bus.ifu_valid = 1'b0;
    bus.ifu_addr  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_we    = 1'b0;
    bus.lsu_memop = 3'b0;
    bus.lsu_addr  = '0;
    bus.lsu_wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_req", 64'(bus.mem_req), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_lsu_rvalid", 64'(bus.lsu_rvalid), 0);
    chk("rst_ifu_rvalid", 64'(bus.ifu_rvalid), 0);
    chk("rst_lsu_err", 64'(bus.lsu_err), 0);

    // Tie after reset: IFU first, then strict alternation
    @(negedge clk);
    rst_n = 1'b1;
    rdy_lat = 0;
    rv_lat  = 0;
    bus.ifu_addr  = 64'h8000_1000;
    bus.lsu_addr  = 64'h8000_2000;
    bus.lsu_memop = 3'b011;
    bus.ifu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      #1;
      if (bus.ifu_ready && bus.lsu_ready)
        chk("double_grant", 1, 0);
      if (bus.ifu_ready) order.push_back(0);
      if (bus.lsu_ready) order.push_back(1);
      @(negedge clk);
    end
    bus.ifu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    chk("arb_grants", 64'(order.size()), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk($sformatf("arb_order%0d", i),
          64'(order[i]), 64'(i % 2));
    repeat (8) @(negedge clk);

    // Vector table, zero-latency memory
    foreach (tv[i]) begin
      xact(tv[i].lsu, tv[i].we, tv[i].op, tv[i].addr,
           tv[i].wd, tv[i].md, 0, 0, got, err, lat, nreq);
      chk($sformatf("v%0d_rdata", i), got, tv[i].exp_rd);
      chk($sformatf("v%0d_err", i),
          64'(err), 64'(tv[i].exp_err));
      chk($sformatf("v%0d_lat", i), 64'(lat),
          tv[i].exp_err ? 64'd1 : 64'd2);
      chk($sformatf("v%0d_nreq", i), 64'(nreq),
          tv[i].exp_err ? 64'd0 : 64'd1);
      if (!tv[i].exp_err) begin
        chk($sformatf("v%0d_maddr", i),
            cap_addr, tv[i].exp_maddr);
        chk($sformatf("v%0d_we", i),
            64'(cap_we), 64'(tv[i].we));
        if (tv[i].we) begin
          chk($sformatf("v%0d_wmask", i),
              64'(cap_wmask), 64'(tv[i].exp_m));
          chk($sformatf("v%0d_wdata", i),
              cap_wdata, tv[i].exp_wd);
        end
      end
    end

    // Stalled store: 3 cycles without mem_ready, ack 2 later
    manual = 1'b1;
    @(negedge clk);
    bus.lsu_we    = 1'b1;
    bus.lsu_memop = 3'b001;
    bus.lsu_addr  = 64'h8000_0005;
    bus.lsu_wdata = 64'hAB;
    bus.lsu_valid = 1'b1;
    #1;
    chk("stall_accept", 64'(bus.lsu_ready), 1);
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    bus.ifu_addr  = 64'h8000_0100;
    bus.ifu_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_req", 64'(bus.mem_req), 1);
      chk("stall_addr", bus.mem_addr, 64'h8000_0000);
      chk("stall_wmask", 64'(bus.mem_wmask), 64'h20);
      chk("stall_wdata", bus.mem_wdata,
          64'h0000_AB00_0000_0000);
      chk("stall_we", 64'(bus.mem_we), 1);
      chk("stall_ifu_ready", 64'(bus.ifu_ready), 0);
      pulses += int'(bus.lsu_rvalid);
      if (i == 3) man_ready = 1'b1;
      @(negedge clk);
    end
    man_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_wait_req", 64'(bus.mem_req), 0);
      chk("stall_wait_ready", 64'(bus.ifu_ready), 0);
      pulses += int'(bus.lsu_rvalid);
      if (i == 1) man_rvalid = 1'b1;
      @(negedge clk);
    end
    man_rvalid = 1'b0;
    bus.ifu_valid = 1'b0;
    #1;
    chk("stall_rvalid", 64'(bus.lsu_rvalid), 1);
    chk("stall_rdata", bus.lsu_rdata, 0);
    chk("stall_err", 64'(bus.lsu_err), 0);
    pulses += int'(bus.lsu_rvalid);
    @(negedge clk); #1;
    pulses += int'(bus.lsu_rvalid);
    chk("stall_pulses", 64'(pulses), 1);

    // Reset while waiting for read data
    @(negedge clk);
    man_rdata     = 64'h5555_AAAA_5555_AAAA;
    bus.lsu_we    = 1'b0;
    bus.lsu_memop = 3'b011;
    bus.lsu_addr  = 64'h8000_0040;
    bus.lsu_valid = 1'b1;
    #1;
    chk("rw_accept", 64'(bus.lsu_ready), 1);
    @(negedge clk);
    bus.lsu_valid = 1'b0;
    #1;
    chk("rw_req", 64'(bus.mem_req), 1);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    #1;
    chk("rw_wait", 64'(bus.mem_req), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw_mem_req", 64'(bus.mem_req), 0);
    chk("rw_mem_addr", bus.mem_addr, 0);
    chk("rw_lsu_rvalid", 64'(bus.lsu_rvalid), 0);
    chk("rw_lsu_rdata", bus.lsu_rdata, 0);
    man_rvalid = 1'b1;
    @(negedge clk);
    man_rvalid = 1'b0;
    pulses = 0;
    repeat (3) begin
      #1;
      pulses += int'(bus.lsu_rvalid) + int'(bus.mem_req);
      @(negedge clk);
    end
    chk("rw_late_ignored", 64'(pulses), 0);
    manual = 1'b0;
    xact(1, 0, 3'b000, 64'h8000_0044, 0,
         64'h7654_3210_FFFF_FFFF, 0, 0,
         got, err, lat, nreq);
    chk("rw_next_rdata", got, 64'h7654_3210);
    chk("rw_next_lat", 64'(lat), 2);

    // Random traffic against the byte-level model
    for (int t = 0; t < 150; t++) begin
      bit          il, w, mis;
      logic [2:0]  op;
      logic [63:0] a, wd, md, exp_rd;
      int          r, k;
      il = ($urandom_range(0, 3) != 0);
      w  = il && ($urandom_range(0, 1) == 1);
      op = 3'($urandom_range(0, 7));
      a  = 64'h8000_0000 + 64'($urandom_range(0, 63));
      wd = {$urandom, $urandom};
      md = {$urandom, $urandom};
      r  = $urandom_range(0, 2);
      k  = $urandom_range(0, 2);
      mis = il && ref_mis(op, a);
      xact(il, w, op, a, wd, md, r, k,
           got, err, lat, nreq);
      exp_rd = !il ? ref_ifu(a, md)
             : (mis || w) ? 64'd0 : ref_load(op, a, md);
      chk($sformatf("r%0d_rdata", t), got, exp_rd);
      chk($sformatf("r%0d_err", t), 64'(err), 64'(mis));
      chk($sformatf("r%0d_lat", t), 64'(lat),
          mis ? 64'd1 : 64'(2 + r + k));
      chk($sformatf("r%0d_nreq", t), 64'(nreq),
          mis ? 64'd0 : 64'd1);
      if (!mis) begin
        chk($sformatf("r%0d_maddr", t), cap_addr,
            {a[63:3], 3'b000});
        chk($sformatf("r%0d_we", t), 64'(cap_we), 64'(w));
        if (w) begin
          chk($sformatf("r%0d_wmask", t),
              64'(cap_wmask), 64'(ref_mask(op, a)));
          chk($sformatf("r%0d_wdata", t),
              cap_wdata, ref_wd(op, a, wd));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_220053_mem_arb.md
Name: ysyx_220053_mem_arb

Overview:
- Arbitrates and sequences a single 64-bit data-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Converts requester byte addresses and MemOp sizes into aligned double-word accesses with a byte write mask.
- On reads, extracts and sign- or zero-extends the returned data.
- Sits between the core pipeline and the pmem/bus adapter. One outstanding memory transaction at a time.

Parameters:
- AW, 64, address width.
- DW, 64, data width; fixed at 64, and the lane logic assumes 8 byte lanes.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- ifu_valid  in  1  fetch request pending
- ifu_addr  in  AW  fetch byte address; access is 4 bytes, zero-extended
- ifu_ready  out  1  request accepted this cycle
- ifu_rvalid  out  1  fetch response valid, 1-cycle pulse
- ifu_rdata  out  DW  fetch data
- lsu_valid  in  1  load/store request pending
- lsu_we  in  1  1 = store
- lsu_memop  in  3  MemOp encoding, see Behaviour
- lsu_addr  in  AW  byte address
- lsu_wdata  in  DW  store data, right-aligned
- lsu_ready  out  1  request accepted this cycle
- lsu_rvalid  out  1  load data or store ack, 1-cycle pulse
- lsu_rdata  out  DW  extended load data; 0 on store or error
- lsu_err  out  1  misaligned access; qualified by lsu_rvalid
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  AW  8-byte-aligned address, low 3 bits forced to 0
- mem_wdata  out  DW  lane-shifted write data
- mem_wmask  out  8  byte write mask
- mem_ready  in  1  memory accepted mem_req
- mem_rvalid  in  1  read data valid / write done
- mem_rdata  in  DW  aligned double-word read data

Behaviour:
- MemOp encoding:
  - 000 word, sign-extended
  - 001 byte, sign-extended
  - 010 half, sign-extended
  - 011 double
  - 100 word, zero-extended
  - 101 byte, zero-extended
  - 110 half, zero-extended
  - 111 reserved: treated as double, read result 0
- Stores use MemOp[1:0] only for size.
- Offset st = addr[2:0]. Write data: mem_wdata = data << (8*st); mem_wmask has size-many ones starting at bit st; double gives 8'hFF. Bytes of mem_wdata outside the mask are 0.
- Read data: extract size bytes from mem_rdata starting at byte st, then extend per MemOp.
- Misalignment: error if st is not a multiple of the access size (half: st[0]; word: st[1:0]; double: st != 0).
  - LSU misaligned request: accepted; no memory transaction is issued; the next cycle gives lsu_rvalid=1, lsu_err=1, lsu_rdata=0.
  - IFU misalignment (addr[1:0] != 0): ifu_rdata=0, with no error port. The fetch is still issued using the aligned address.
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
  - IDLE: grant when any valid. The requester is captured (addr/op/data registered), and ready is asserted combinationally for that one cycle.
    - Next state is REQ, or ERR for a misaligned LSU request.
  - REQ: mem_req=1 and mem_addr/we/wdata/wmask are held stable. mem_ready=1 → WAIT.
  - WAIT: mem_req=0. mem_rvalid=1 → latch mem_rdata, go to RESP. If mem_rvalid arrives in the same cycle as mem_ready (REQ), go directly to RESP.
  - RESP: the owner's rvalid=1 for exactly one cycle with processed data → IDLE.
  - ERR: lsu_rvalid=1, lsu_err=1 → IDLE.
- Arbitration: 1-bit last-grant register.
  - When both are valid in IDLE, grant the requester that was not granted last.
  - When only one is valid, grant it. Reset value of last-grant = LSU, so the IFU wins the first tie.
- No grants outside IDLE; ifu_ready and lsu_ready are 0 in every other state. Requesters hold valid and payload until ready.
- Latency: accept at cycle T, mem_req at T+1. If mem_ready and mem_rvalid both arrive at T+1, rvalid reaches the requester at T+2. This is the minimum.
- Stores complete only on mem_rvalid (write ack). lsu_rdata=0 for stores.
- Reset (rst_n=0 sampled at a clk edge) from any state:
  - FSM → IDLE; all outputs 0; last-grant = LSU.
  - A mid-transaction reset abandons the access: no response pulse is generated.
  - mem_rvalid arriving in IDLE is ignored.

Test Plan:
- LSU load, memop=000, addr=0x8000_0004, mem_rdata=0x8765_4321_0000_0000 → mem_addr=0x8000_0000, mem_wmask don't-care with mem_we=0, lsu_rdata=0xFFFF_FFFF_8765_4321.
- LSU store, memop=001, addr=...0x5, wdata=0xAB → mem_wmask=8'b0010_0000, mem_wdata=0x0000_AB00_0000_0000. lsu_rvalid follows mem_rvalid by 1 cycle with lsu_rdata=0.
- IFU and LSU valid together in IDLE after reset → IFU granted first, then LSU. Repeat with both held valid → grants alternate I,L,I,L.
- LSU memop=010 at addr ending 0x3 → no mem_req ever; lsu_rvalid=1, lsu_err=1 the cycle after lsu_ready.
- Memory stalls: mem_ready low for 3 cycles, then mem_rvalid 2 cycles later → mem_req and payload held stable throughout; exactly one rvalid pulse; requester ready stays 0.
- rst_n=0 asserted in WAIT → next cycle IDLE, all outputs 0, no rvalid pulse. A late mem_rvalid is ignored, and the next request proceeds normally.
